// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative restoring divider, start/busy/done handshake; optional signed mode under DIV_SEQ_SIGNED_EN
module div_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
`ifdef DIV_SEQ_SIGNED_EN
  input  logic         sgn,
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   p_q, p_d;       // partial remainder
  logic [N-1:0]   q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [N-1:0]   d_q, d_d;       // divisor magnitude
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;
  logic           negq_q, negq_d; // quotient must be negated at the end
  logic           negr_q, negr_d; // remainder must be negated at the end
  logic           ovf_q, ovf_d;

  logic           signed_op;
  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     shifted, trial;
  logic [N-1:0]   step_p, step_q;

`ifdef DIV_SEQ_SIGNED_EN
  assign signed_op = sgn;
`else
  assign signed_op = 1'b0;
`endif

  // Operand magnitudes at capture; the core only ever sees unsigned values
  always_comb begin
    a_neg = signed_op & dividend[N-1];
    b_neg = signed_op & divisor[N-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
  end

  // One restoring step: shift {P,Q} left, trial-subtract D one bit wider than P
  always_comb begin
    shifted = {p_q, q_q[N-1]};
    trial   = shifted - {1'b0, d_q};
    step_p  = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    step_q  = {q_q[N-2:0], ~trial[N]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d    = '0;
          q_d    = a_mag;
          d_d    = b_mag;
          cnt_d  = '0;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          dz_d   = (divisor == '0);
          ovf_d  = signed_op && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
          if (divisor == '0) begin
            // Divide-by-zero skips the core entirely
            quo_d   = '1;
            rem_d   = dividend;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        p_d   = step_p;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          quo_d   = negq_q ? (~step_q + 1'b1) : step_q;
          rem_d   = negr_q ? (~step_p + 1'b1) : step_p;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
`ifdef DIV_SEQ_SIGNED_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq (N=8)
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dz;
`ifdef DIV_SEQ_SIGNED_EN
  logic       sgn;
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  div_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef DIV_SEQ_SIGNED_EN
    .sgn       (sgn),
    .ovf       (ovf),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to its done pulse and the idle cycle after
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int elat);
    int lat;
    int busy_n;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'hAA; divisor = 8'h55;
    lat = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) busy_n++;
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy_cycles"}, busy_n, elat);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dz"}, dz, edz);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_held_quo"}, quotient, eq);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV_SEQ_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quo", quotient, 8'd0);
    check("rst_rem", remainder, 8'd0);
    check("rst_dz", dz, 1'b0);
    rst = 1'b0;

    run_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    run_op("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9);
    run_op("d77_0", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
    run_op("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9);

    // start pulses during RUN and during DONE must both be ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check("ign_run_busy", busy, 1'b1);
    lat = 4;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, 9);
    check("ign_quo", quotient, 8'd15);
    check("ign_rem", remainder, 8'd5);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check("ign_after_done_busy", busy, 1'b0);
    @(negedge clk);
    check("ign_still_idle", busy, 1'b0);
    check("ign_held_quo", quotient, 8'd15);

    // reset in the middle of RUN discards the operation
    @(negedge clk);
    start = 1'b1; dividend = 8'd180; divisor = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_quo", quotient, 8'd0);
    check("mid_rst_rem", remainder, 8'd0);
    check("mid_rst_dz", dz, 1'b0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    run_op("d9_4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 9);

`ifdef DIV_SEQ_SIGNED_EN
    sgn = 1'b1;
    run_op("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9);
    check("s_m7_2_ovf", ovf, 1'b0);
    run_op("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
    check("s_7_m2_ovf", ovf, 1'b0);
    run_op("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    check("s_m128_m1_ovf", ovf, 1'b1);
    sgn = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
